seq_det_prog: RTL and testbench
===============================

// Module: seq_det_prog
// PURPOSE
//  Parametrised, run-time programmable serial pattern detector; successor to the fixed 7-bit flag detector.
//  Samples one bit per qualified clock and compares the last LEN bits against a loaded pattern.
//  Emits a registered one-cycle match pulse and keeps a saturating match count.
//  Overlapping or non-overlapping detection is selectable; sits between the bit deserialiser and framing logic.
// PARAMETERS
//  MAX_LEN  8          maximum pattern length in bits (>=2)
//  DEF_PAT  8'h3E      pattern loaded at reset (LSB = newest bit; 0111110 for DEF_LEN=7)
//  DEF_LEN  7          pattern length loaded at reset (1..MAX_LEN)
//  CNT_W    8          match counter width
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, asynchronous, active-high
//  bit_vld    in   1          ser_in is valid this cycle
//  ser_in     in   1          serial data bit
//  overlap    in   1          1 = overlapping detection, 0 = history discarded after a match
//  cfg_we     in   1          load cfg_pat/cfg_len (and cfg_mask) this cycle
//  cfg_pat    in   MAX_LEN    new pattern; bit LEN-1 is received first, bit 0 last
//  cfg_len    in   LW         new length; LW = $clog2(MAX_LEN+1)
//  cnt_clr    in   1          synchronous clear of match_cnt
//  match      out  1          one-cycle pulse, the cycle after the completing bit
//  armed      out  1          history holds >= LEN valid bits
//  cfg_err    out  1          one-cycle pulse: rejected configuration write
//  match_cnt  out  CNT_W      saturating number of matches
// BEHAVIOUR
//  Reset (async): pat=DEF_PAT, len=DEF_LEN, hist=0, fill=0; match=0, armed=0, cfg_err=0, match_cnt=0.
//  Reset mid-stream discards all partial history; outputs drop immediately.
//  State = fill counter (0..len): FILL while fill<len, ARMED when fill==len.
//  Bit cycle (bit_vld=1, cfg_we=0): hist_n={hist[MAX_LEN-2:0],ser_in}; fill_n=min(fill+1,len).
//  hit = (fill_n==len) && (hist_n[len-1:0]==pat[len-1:0]).
//  match <= hit (latency 1 cycle from completing bit); no hit -> match<=0.
//  hit && overlap=0 -> fill<=0 (back to FILL; next match needs len new bits).
//  hit && overlap=1 -> fill<=len (suffix reuse allowed).
//  bit_vld=0: hist/fill hold, match<=0.
//  cfg_we=1, 1<=cfg_len<=MAX_LEN: pat/len load, hist=0, fill=0, match<=0; a bit the same cycle is discarded.
//  cfg_we=1, cfg_len==0 or >MAX_LEN: config unchanged, history unchanged, that cycle's bit processed normally, cfg_err<=1 for one cycle.
//  Pattern bits above len are ignored.
//  match_cnt: +1 per hit, saturates at 2**CNT_W-1.
//  cnt_clr && hit same cycle -> match_cnt=1; cnt_clr alone -> 0.
//  armed = (fill==len), registered with state.
// CONFIGURATION
//  SEQ_DET_MASK_EN defined:
//   - Adds port cfg_mask in MAX_LEN, loaded with cfg_pat (reset value 0).
//   - Mask bit 1 = don't-care in compare.
//   - Compare is ((hist_n^pat)&~mask)[len-1:0]==0.
//  Undefined: port absent; exact compare.
// STRUCTURE
//  Package seq_det_pkg:
//   - MAX_LEN default, len_t (LW bits)
//   - DEF_PAT/DEF_LEN constants
//   - len_mask(len) function
//  Sub-module seq_det_sat_cnt: CNT_W saturating counter with inc/clr (clr+inc -> 1).
// TESTING
//  Default cfg, overlap=1, bits 0111110 then 111110 -> match after bit 7 and bit 13; match_cnt=2.
//  Same stream, overlap=0 -> single match after bit 7; armed=0 after it; match_cnt=1.
//  0111110 with bit_vld low for 3 cycles between bits 4 and 5 -> single match, one cycle after bit 7.
//  cfg pat=3'b101 len=3, overlap=1, bits 10101 -> matches after bits 3 and 5.
//  Next, cfg_len=0 -> cfg_err pulse; 101 still matches.
//  CNT_W=2, 5 matches -> match_cnt=3; cnt_clr coincident with a match -> match_cnt=1.
//  rst after 4 bits of 0111110, then 110 -> no match.
//  Full 0111110 after reset -> match.
//  MASK_EN on: pat 0111110, mask 0001000 -> 0110110 matches.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and constants for the programmable serial pattern detector.
//   SEQ_MAX_LEN  default maximum pattern length
//   len_t        pattern length type (LW bits) at the default maximum length
//   SEQ_DEF_PAT  pattern loaded at reset, LSB = newest bit (0111110 for length 7)
//   SEQ_DEF_LEN  pattern length loaded at reset
//   phase_e      detector phase: still filling history, or armed
//   len_mask()   returns a mask with the low 'len' bits set (up to 32 bits)
package seq_det_pkg;

  localparam int unsigned SEQ_MAX_LEN = 8;
  localparam int unsigned SEQ_LW      = $clog2(SEQ_MAX_LEN + 1);

  typedef logic [SEQ_LW-1:0] len_t;

  localparam logic [SEQ_MAX_LEN-1:0] SEQ_DEF_PAT = 8'h3E;
  localparam int unsigned            SEQ_DEF_LEN = 7;

  typedef enum logic {
    PhFill,
    PhArmed
  } phase_e;

  // Wide result so any MAX_LEN up to 32 can take its low slice by a cast.
  function automatic logic [31:0] len_mask(input int unsigned len);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: saturating up-counter with synchronous clear.
//   clk    clock, rising edge
//   rst    asynchronous active-high reset, clears the count
//   inc_i  add one (held at all-ones once reached)
//   clr_i  synchronous clear; clear together with inc yields 1
//   cnt_o  current count
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: run-time programmable serial pattern detector.
// Shifts in one bit per qualified cycle and compares the newest LEN bits with a loaded
// pattern (pattern bit LEN-1 is the oldest bit, bit 0 the newest). A hit gives a registered
// one-cycle match pulse and bumps a saturating match counter. Overlapping or
// non-overlapping detection is selected by overlap_i.
// Optional feature: define SEQ_DET_MASK_EN to add cfg_mask_i (1 = don't-care bit).
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   bit_vld_i    ser_in_i is valid this cycle
//   ser_in_i     serial data bit
//   overlap_i    1 = overlapping detection, 0 = history discarded after a match
//   cfg_we_i     load cfg_pat_i/cfg_len_i (and cfg_mask_i) this cycle
//   cfg_pat_i    new pattern
//   cfg_len_i    new length, valid range 1..MAX_LEN
//   cfg_mask_i   new don't-care mask (SEQ_DET_MASK_EN only)
//   cnt_clr_i    synchronous clear of match_cnt_o
//   match_o      one-cycle pulse the cycle after the completing bit
//   armed_o      history holds at least LEN valid bits
//   cfg_err_o    one-cycle pulse after a rejected configuration write
//   match_cnt_o  saturating match count
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN = SEQ_MAX_LEN,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(SEQ_DEF_PAT),
  parameter int unsigned        DEF_LEN = SEQ_DEF_LEN,
  parameter int unsigned        CNT_W   = 8,
  localparam int unsigned       LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_vld_i,
  input  logic               ser_in_i,
  input  logic               overlap_i,
  input  logic               cfg_we_i,
  input  logic [MAX_LEN-1:0] cfg_pat_i,
  input  logic [LW-1:0]      cfg_len_i,
`ifdef SEQ_DET_MASK_EN
  input  logic [MAX_LEN-1:0] cfg_mask_i,
`endif
  input  logic               cnt_clr_i,
  output logic               match_o,
  output logic               armed_o,
  output logic               cfg_err_o,
  output logic [CNT_W-1:0]   match_cnt_o
);

  // Configuration and history state. Only MAX_LEN-1 history bits are stored: the newest
  // bit comes straight from ser_in_i when the compare is made.
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  phase_e             phase_q, phase_d;
  logic               match_q, cfg_err_q;
  logic [MAX_LEN-1:0] mask_q;
`ifdef SEQ_DET_MASK_EN
  logic [MAX_LEN-1:0] mask_d;
`else
  assign mask_q = '0;
`endif

  logic               cfg_ok;
  logic               bit_cyc;
  logic [MAX_LEN-1:0] hist_n;
  logic [LW-1:0]      fill_n;
  logic [MAX_LEN-1:0] lmask;
  logic [MAX_LEN-1:0] diff;
  logic               hit;

  assign cfg_ok  = cfg_we_i && (cfg_len_i != '0) && (32'(cfg_len_i) <= MAX_LEN);
  // A valid configuration write swallows any bit presented in the same cycle.
  assign bit_cyc = bit_vld_i && !cfg_ok;

  assign hist_n = {hist_q, ser_in_i};
  assign fill_n = (fill_q == len_q) ? len_q : fill_q + LW'(1);

  // Bits above len and masked bits never take part in the compare.
  assign lmask = MAX_LEN'(len_mask(32'(len_q)));
  assign diff  = (hist_n ^ pat_q) & ~mask_q & lmask;
  assign hit   = bit_cyc && (fill_n == len_q) && (diff == '0);

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    hist_d = hist_q;
    fill_d = fill_q;
`ifdef SEQ_DET_MASK_EN
    mask_d = mask_q;
`endif
    if (cfg_ok) begin
      pat_d  = cfg_pat_i;
      len_d  = cfg_len_i;
      hist_d = '0;
      fill_d = '0;
`ifdef SEQ_DET_MASK_EN
      mask_d = cfg_mask_i;
`endif
    end else if (bit_vld_i) begin
      hist_d = hist_n[MAX_LEN-2:0];
      // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
      fill_d = (hit && !overlap_i) ? '0 : fill_n;
    end
    phase_d = (fill_d == len_d) ? PhArmed : PhFill;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q     <= DEF_PAT;
      len_q     <= LW'(DEF_LEN);
      hist_q    <= '0;
      fill_q    <= '0;
      phase_q   <= PhFill;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef SEQ_DET_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      phase_q   <= phase_d;
      match_q   <= hit;
      cfg_err_q <= cfg_we_i && !cfg_ok;
`ifdef SEQ_DET_MASK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (hit),
    .clr_i (cnt_clr_i),
    .cnt_o (match_cnt_o)
  );

  assign match_o   = match_q;
  assign armed_o   = (phase_q == PhArmed);
  assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: directed bench for seq_det_prog. A queue-based model predicts every
// output each cycle; hand-computed checks pin the expected behaviour at key points.
// A second instance with CNT_W=2 exercises counter saturation on the same stimulus.
module tb_seq_det_prog;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       bit_vld = 1'b0;
  logic       ser_in  = 1'b0;
  logic       overlap = 1'b1;
  logic       cfg_we  = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic       cnt_clr = 1'b0;
`ifdef SEQ_DET_MASK_EN
  logic [7:0] cfg_mask = '0;
`endif

  logic       match, armed, cfg_err;
  logic [7:0] cnt;
  logic       match2, armed2, cfg_err2;
  logic [1:0] cnt2;

  seq_det_prog dut (
    .clk         (clk),
    .rst         (rst),
    .bit_vld_i   (bit_vld),
    .ser_in_i    (ser_in),
    .overlap_i   (overlap),
    .cfg_we_i    (cfg_we),
    .cfg_pat_i   (cfg_pat),
    .cfg_len_i   (cfg_len),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask_i  (cfg_mask),
`endif
    .cnt_clr_i   (cnt_clr),
    .match_o     (match),
    .armed_o     (armed),
    .cfg_err_o   (cfg_err),
    .match_cnt_o (cnt)
  );

  seq_det_prog #(
    .CNT_W (2)
  ) dut2 (
    .clk         (clk),
    .rst         (rst),
    .bit_vld_i   (bit_vld),
    .ser_in_i    (ser_in),
    .overlap_i   (overlap),
    .cfg_we_i    (cfg_we),
    .cfg_pat_i   (cfg_pat),
    .cfg_len_i   (cfg_len),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask_i  (cfg_mask),
`endif
    .cnt_clr_i   (cnt_clr),
    .match_o     (match2),
    .armed_o     (armed2),
    .cfg_err_o   (cfg_err2),
    .match_cnt_o (cnt2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the valid bits received since the last reset / config load / non-overlap match.
  logic [7:0] m_pat  = 8'h3E;
  int         m_len  = 7;
  logic [7:0] m_mask = '0;
  bit         m_q[$];
  logic       e_match = 1'b0, e_armed = 1'b0, e_err = 1'b0;
  int         e_cnt = 0, e_cnt2 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pat   <= 8'h3E;
      m_len   <= 7;
      m_mask  <= '0;
      m_q.delete();
      e_match <= 1'b0;
      e_armed <= 1'b0;
      e_err   <= 1'b0;
      e_cnt   <= 0;
      e_cnt2  <= 0;
    end else begin
      automatic bit ok  = cfg_we && (cfg_len >= 1) && (cfg_len <= 8);
      automatic bit h   = 1'b0;
      automatic int len = m_len;
      automatic int c1  = e_cnt;
      automatic int c2  = e_cnt2;
      if (ok) begin
        m_pat <= cfg_pat;
        m_len <= int'(cfg_len);
        len   = int'(cfg_len);
`ifdef SEQ_DET_MASK_EN
        m_mask <= cfg_mask;
`endif
        m_q.delete();
      end else if (bit_vld) begin
        m_q.push_back(ser_in);
        if (m_q.size() > 8) void'(m_q.pop_front());
        if (m_q.size() >= len) begin
          h = 1'b1;
          for (int k = 0; k < len; k++) begin
            if (!m_mask[k] && (m_q[m_q.size() - 1 - k] != m_pat[k])) h = 1'b0;
          end
        end
        if (h && !overlap) m_q.delete();
      end
      e_match <= h;
      e_err   <= cfg_we && !ok;
      e_armed <= (m_q.size() >= len);
      if (cnt_clr) begin
        c1 = h ? 1 : 0;
        c2 = h ? 1 : 0;
      end else if (h) begin
        if (c1 < 255) c1++;
        if (c2 < 3) c2++;
      end
      e_cnt  <= c1;
      e_cnt2 <= c2;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_match", 32'(match), 32'(e_match));
    check("cyc_armed", 32'(armed), 32'(e_armed));
    check("cyc_cfg_err", 32'(cfg_err), 32'(e_err));
    check("cyc_cnt", 32'(cnt), 32'(e_cnt));
    check("cyc_match2", 32'(match2), 32'(e_match));
    check("cyc_cnt2", 32'(cnt2), 32'(e_cnt2));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    bit_vld = 1'b1;
    ser_in  = b;
    tick();
    bit_vld = 1'b0;
  endtask

  // Sends n bits, oldest (bit n-1) first.
  task automatic send_seq(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len);
    cfg_we  = 1'b1;
    cfg_pat = pat;
    cfg_len = len;
    tick();
    cfg_we  = 1'b0;
  endtask

  initial begin
    do_reset();
    check("reset_match", 32'(match), 0);
    check("reset_armed", 32'(armed), 0);
    check("reset_cfg_err", 32'(cfg_err), 0);
    check("reset_cnt", 32'(cnt), 0);

    // Overlapping: 0111110 then 111110 -> matches after bits 7 and 13.
    overlap = 1'b1;
    send_seq(32'b0111110, 7);
    check("ov_match_b7", 32'(match), 1);
    check("ov_armed_b7", 32'(armed), 1);
    send(1'b1);
    check("ov_nomatch_b8", 32'(match), 0);
    send_seq(32'b11110, 5);
    check("ov_match_b13", 32'(match), 1);
    check("ov_cnt", 32'(cnt), 2);

    // Non-overlapping: single match, armed drops with it.
    do_reset();
    overlap = 1'b0;
    send_seq(32'b0111110, 7);
    check("nov_match_b7", 32'(match), 1);
    check("nov_armed_b7", 32'(armed), 0);
    send_seq(32'b111110, 6);
    check("nov_nomatch_b13", 32'(match), 0);
    check("nov_cnt", 32'(cnt), 1);

    // Reset mid-stream: outputs drop before any clock edge, history is discarded.
    send_seq(32'b0111, 4);
    check("pre_rst_armed", 32'(armed), 1);
    rst = 1'b1;
    #1;
    check("rst_async_armed", 32'(armed), 0);
    check("rst_async_cnt", 32'(cnt), 0);
    tick();
    rst = 1'b0;
    overlap = 1'b1;
    send(1'b1);
    check("rst_nomatch_1", 32'(match), 0);
    send(1'b1);
    check("rst_nomatch_2", 32'(match), 0);
    send(1'b0);
    check("rst_nomatch_3", 32'(match), 0);
    send_seq(32'b0111110, 7);
    check("rst_full_match", 32'(match), 1);

    // bit_vld gaps inside the pattern.
    do_reset();
    send_seq(32'b0111, 4);
    tick();
    tick();
    tick();
    check("gap_idle_match", 32'(match), 0);
    send_seq(32'b110, 3);
    check("gap_match", 32'(match), 1);
    tick();
    check("gap_pulse_end", 32'(match), 0);

    // Programmed pattern 101, len 3; bits above len set to show they are ignored.
    configure(8'b1111_1101, 4'd3);
    check("cfg_armed_clear", 32'(armed), 0);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    check("p3_match_b3", 32'(match), 1);
    send(1'b0);
    check("p3_nomatch_b4", 32'(match), 0);
    send(1'b1);
    check("p3_match_b5", 32'(match), 1);

    // Rejected config (len 0) with a bit in the same cycle: bit still counts.
    cfg_we  = 1'b1;
    cfg_len = 4'd0;
    bit_vld = 1'b1;
    ser_in  = 1'b0;
    tick();
    cfg_we  = 1'b0;
    bit_vld = 1'b0;
    check("err0_pulse", 32'(cfg_err), 1);
    send(1'b1);
    check("err0_pulse_end", 32'(cfg_err), 0);
    check("err0_still_match", 32'(match), 1);
    configure(8'h00, 4'd9);
    check("err9_pulse", 32'(cfg_err), 1);
    check("err9_armed_kept", 32'(armed), 1);

    // Valid config discards a bit presented the same cycle.
    bit_vld = 1'b1;
    ser_in  = 1'b1;
    configure(8'b101, 4'd3);
    bit_vld = 1'b0;
    send(1'b0);
    send(1'b1);
    check("cfg_bit_dropped", 32'(match), 0);
    send(1'b0);
    send(1'b1);
    check("cfg_after_drop_match", 32'(match), 1);

    // Counter saturation (CNT_W=2 instance) and clear.
    do_reset();
    configure(8'b101, 4'd3);
    send_seq(32'b10101010101, 11);
    check("sat_cnt8", 32'(cnt), 5);
    check("sat_cnt2", 32'(cnt2), 3);
    send(1'b0);
    cnt_clr = 1'b1;
    send(1'b1);
    cnt_clr = 1'b0;
    check("clr_hit_match", 32'(match), 1);
    check("clr_hit_cnt8", 32'(cnt), 1);
    check("clr_hit_cnt2", 32'(cnt2), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_only_cnt8", 32'(cnt), 0);

`ifdef SEQ_DET_MASK_EN
    // Don't-care bit 3: 0110110 matches 0111110.
    do_reset();
    cfg_mask = 8'b0001000;
    configure(8'b0111110, 4'd7);
    cfg_mask = '0;
    send_seq(32'b0110110, 7);
    check("mask_match", 32'(match), 1);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
